// File: rtl/dmem_arbiter_if.sv
// +------------------------------------------------------------------+
// | dmem_arbiter_if : core, debug and memory-side bus of the arbiter |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface dmem_arbiter_if;
    logic        c_req_i;
    logic        c_we_i;
    logic [31:0] c_addr_i;
    logic [31:0] c_wdata_i;
    logic [31:0] c_rdata_o;
    logic        c_stall_o;

    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;

    logic [31:0] m_addr_o;
    logic [31:0] m_wdata_o;
    logic        m_we_o;
    logic [31:0] m_rdata_i;

    modport slave (
        input  c_req_i, c_we_i, c_addr_i, c_wdata_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  m_rdata_i,
        output c_rdata_o, c_stall_o,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output m_addr_o, m_wdata_o, m_we_o
    );

    modport master (
        output c_req_i, c_we_i, c_addr_i, c_wdata_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output m_rdata_i,
        input  c_rdata_o, c_stall_o,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  m_addr_o, m_wdata_o, m_we_o
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// +------------------------------------------------------------------+
// | dmem_arbiter : shares the data-memory port between the core and  |
// | a debug/DMA master. Define DMEM_ARB_RR_EN for round-robin,       |
// | otherwise fixed core priority with a debug starvation counter.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module dmem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  wire logic       clk_i,
    input  wire logic       rst_ni,
    dmem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    owner_t      w_owner;
    logic        w_dbg_win;
    logic        w_dbg_rd;
    logic        r_rvalid;
    logic [31:0] r_rdata;

`ifdef DMEM_ARB_RR_EN
    // 1 = debug owned the last granted cycle; reset value hands the first tie to the core
    logic r_last_dbg;

    assign w_dbg_win = bus.d_req_i & (~bus.c_req_i | ~r_last_dbg);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_dbg <= 1'b1;
        end else if (bus.c_req_i || bus.d_req_i) begin
            r_last_dbg <= w_dbg_win;
        end
    end
`else
    localparam logic [3:0] c_starve_lim = 4'(STARVE_MAX);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_range_check
        $error("dmem_arbiter: STARVE_MAX must be in 1..15");
    end

    logic [3:0] r_starve_cnt;

    assign w_dbg_win = bus.d_req_i & (~bus.c_req_i | (r_starve_cnt == c_starve_lim));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_starve_cnt <= 4'd0;
        end else if (!bus.d_req_i || w_dbg_win) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != c_starve_lim) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`endif

    always_comb begin
        w_owner = OWN_NONE;
        if (w_dbg_win) begin
            w_owner = OWN_DBG;
        end else if (bus.c_req_i) begin
            w_owner = OWN_CORE;
        end
    end

    // NONE leaves the core payload on the bus with the write strobe off
    always_comb begin
        bus.m_addr_o  = bus.c_addr_i;
        bus.m_wdata_o = bus.c_wdata_i;
        bus.m_we_o    = 1'b0;
        bus.d_gnt_o   = 1'b0;
        bus.c_stall_o = 1'b0;
        case (w_owner)
            OWN_CORE: begin
                bus.m_we_o = bus.c_we_i;
            end
            OWN_DBG: begin
                bus.m_addr_o  = bus.d_addr_i;
                bus.m_wdata_o = bus.d_wdata_i;
                bus.m_we_o    = bus.d_we_i;
                bus.d_gnt_o   = 1'b1;
                bus.c_stall_o = bus.c_req_i;
            end
            default: begin
            end
        endcase
    end

    assign bus.c_rdata_o = bus.m_rdata_i;
    assign w_dbg_rd      = w_dbg_win & ~bus.d_we_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_rvalid <= w_dbg_rd;
            if (w_dbg_rd) begin
                r_rdata <= bus.m_rdata_i;
            end
        end
    end

    assign bus.d_rvalid_o = r_rvalid;
    assign bus.d_rdata_o  = r_rdata;

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter in front of the single-ported data memory/LSU. Shares the memory port between the single-cycle core's load/store path and a debug/DMA master. Stalls the core for exactly one cycle whenever the debug master owns the port. Bounds debug starvation with a counter, or with round-robin when compiled in.

## Interface
- `STARVE_MAX`, default 4: consecutive cycles a debug request may be denied before a forced debug grant (fixed-priority build only); legal range 1..15.
- `clk_i`  in  1  system clock; all state updates on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `c_req_i`  in  1  core load/store this cycle.
- `c_we_i`  in  1  core store (1) / load (0).
- `c_addr_i`  in  32  core byte address (ALU result).
- `c_wdata_i`  in  32  core store data.
- `c_rdata_o`  out  32  core load data, combinational from `m_rdata_i`.
- `c_stall_o`  out  1  core must hold PC and suppress regfile write this cycle.
- `d_req_i`  in  1  debug request; held with stable payload until `d_gnt_o`.
- `d_we_i`  in  1  debug write (1) / read (0).
- `d_addr_i`  in  32  debug byte address.
- `d_wdata_i`  in  32  debug write data.
- `d_gnt_o`  out  1  debug access performed this cycle.
- `d_rvalid_o`  out  1  registered debug read data valid.
- `d_rdata_o`  out  32  registered debug read data.
- `m_addr_o`, `m_wdata_o`  out  32 each  memory address/write data.
- `m_we_o`  out  1  memory write enable, sampled by the memory on the rising edge.
- `m_rdata_i`  in  32  memory read data, combinational from `m_addr_o`.

## Operation
- Owner is chosen combinationally each cycle: NONE, CORE, or DBG.
- Only `c_req_i` set: CORE. Only `d_req_i` set: DBG. Neither set: NONE.
- Both set, fixed priority: CORE, unless `starve_cnt == STARVE_MAX`, in which case DBG.
- `starve_cnt` (4 bits) increments on each cycle where `d_req_i` is set but DBG is not granted. It clears when DBG is granted or when `d_req_i` is low. It saturates at `STARVE_MAX`.
- CORE owner:
  - `m_addr_o`/`m_wdata_o` are the core payload.
  - `m_we_o = c_we_i`.
  - `c_stall_o = 0`.
- DBG owner:
  - `m_addr_o`/`m_wdata_o` are the debug payload.
  - `m_we_o = d_we_i`.
  - `d_gnt_o = 1`.
  - `c_stall_o = c_req_i`.
- NONE owner: `m_addr_o = c_addr_i`, `m_we_o = 0`, `m_wdata_o = c_wdata_i`.
- `c_rdata_o` is always `m_rdata_i`; its value is meaningful only when owner is CORE.
- Debug read response: on a DBG grant with `d_we_i = 0`, register `d_rdata_o <= m_rdata_i` and `d_rvalid_o <= 1`. Otherwise `d_rvalid_o <= 0`, and `d_rdata_o` holds its value.
- A stalled core retries the same access next cycle because PC is held. The arbiter keeps no core-side state.
- Writes are never merged or reordered. Each grant is exactly one memory access.

## Timing
- Core access: zero-latency, same-cycle, as without the arbiter.
- Debug access: `d_gnt_o` is combinational in the access cycle. `d_rvalid_o`/`d_rdata_o` appear in the following cycle as a one-cycle pulse.
- Debug wait, fixed priority, continuous core traffic: at most `STARVE_MAX` + 1 cycles from `d_req_i` rising to `d_gnt_o`.
- Back-to-back debug requests may be granted every cycle. Each read yields one `d_rvalid_o` pulse.
- Reset (async, any time including mid-access) forces:
  - `starve_cnt = 0`, `last_dbg = 1`.
  - `d_rvalid_o = 0`, `d_rdata_o = 0`.
  - A pending debug response is discarded.
- Combinational outputs during reset follow the owner rules with counters at their reset values.
- Registered outputs are 0 in the first cycle after reset release.
- `d_req_i` dropped before grant: the request is abandoned with no access, and `starve_cnt` clears.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin replaces the fixed-priority rule.
  - Registered `last_dbg` records the owner of the last granted cycle: 1 = DBG, 0 = CORE.
  - When both request, grant DBG if `last_dbg == 0`, else CORE. Strict alternation, worst-case wait 1 cycle.
  - `starve_cnt` and `STARVE_MAX` are unused and not synthesized.
  - `last_dbg` is not updated on NONE cycles.
- Not defined: fixed priority with starvation counter as above. `last_dbg` is not synthesized.

## Test plan
- Core only, store 0xDEADBEEF to 0x10, then load 0x10 → `m_we_o = 1` in the store cycle; `c_rdata_o = 0xDEADBEEF` in the load cycle; `c_stall_o` stays 0.
- Debug only, read 0x20 holding 0x12345678 → `d_gnt_o = 1` in cycle N; `d_rvalid_o = 1`, `d_rdata_o = 0x12345678` in N+1; `d_rvalid_o = 0` in N+2.
- Fixed priority, `STARVE_MAX = 4`, `c_req_i` and `d_req_i` held high → first `d_gnt_o` in the 5th cycle of contention, with `c_stall_o = 1` in that cycle only.
- With `DMEM_ARB_RR_EN`, both requesting for 6 cycles from reset → grants CORE, DBG, CORE, DBG, CORE, DBG; `c_stall_o` is high on the DBG cycles.
- Debug write of 0xA5A5A5A5 to 0x40 colliding with a core load of 0x40 → the granted write lands; the core retries and reads 0xA5A5A5A5.
- `rst_ni` asserted in the cycle after a debug read grant → `d_rvalid_o` is 0 immediately, asynchronously, and no pulse appears after release.
